// File: rtl/fpu_sequencer_pkg.sv
// Shared encodings and helpers for the FPU issue sequencer.
package fpu_sequencer_pkg;

   localparam int CNTW = 6;

   localparam logic [1:0] FP_ADD = 2'b00;
   localparam logic [1:0] FP_SUB = 2'b01;
   localparam logic [1:0] FP_MUL = 2'b10;
   localparam logic [1:0] FP_DIV = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_WB    = 2'd3;

   typedef logic [CNTW-1:0] cnt_t;

   // Fixed latency for the non-divide ops; sub shares the adder latency.
   function automatic cnt_t fixed_lat(input logic [1:0] op, input int add_lat, input int mul_lat);
      cnt_t lat;
      if (op == FP_MUL) begin
         lat = cnt_t'(mul_lat);
      end else begin
         lat = cnt_t'(add_lat);
      end
      return lat;
   endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Issue/FPU handshake bundle between the control FSM, the FPU and the sequencer.
interface fpu_sequencer_if;
   logic       Start;
   logic [1:0] FpOp;
   logic [3:0] Rd;
   logic       Abort;
   logic       FPUDone;
   logic       FPUStart;
   logic [1:0] FPUOp;
   logic       Stall;
   logic       FPUWrite;
   logic [3:0] WA3F;
   logic       Busy;
   logic       FpErr;

   modport master (
      output Start, FpOp, Rd, Abort, FPUDone,
      input  FPUStart, FPUOp, Stall, FPUWrite, WA3F, Busy, FpErr
   );

   modport slave (
      input  Start, FpOp, Rd, Abort, FPUDone,
      output FPUStart, FPUOp, Stall, FPUWrite, WA3F, Busy, FpErr
   );
endinterface

// File: rtl/fpu_sequencer_latcnt.sv
// Loadable down-counter used to time FPU op latency and the divide timeout.
module fpu_latcnt
   import fpu_sequencer_pkg::*;
#(
   parameter int W = CNTW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   input  logic         clr,
   output logic         is_one
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // Next count: clear beats load beats decrement; never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {W{1'b0}};
      end else if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != {W{1'b0}})) begin
         count_d = count_q - W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign is_one = (count_q == W'(1));

endmodule

// File: rtl/fpu_sequencer.sv
// Sequences multi-cycle FPU ops: start pulse, latency/timeout tracking, stall and
// a registered write-back pulse carrying the latched destination.
module fpu_sequencer
   import fpu_sequencer_pkg::*;
#(
   parameter int ADD_LAT     = 2,
   parameter int MUL_LAT     = 3,
   parameter int DIV_TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            reset,
   fpu_sequencer_if.slave  bus
);

   logic [1:0] state_d, state_q;
   logic [1:0] op_d, op_q;
   logic [3:0] rd_d, rd_q;
   logic       err_d, err_q;
   logic       fpu_start_d, fpu_start_q;
   logic       stall_d, stall_q;
   logic       fpu_write_d, fpu_write_q;
   logic       busy_d, busy_q;

   logic       accept_s;
   logic       cnt_load_s, cnt_dec_s, cnt_clr_s, cnt_is_one_s;
   cnt_t       cnt_val_s;
   cnt_t       lat_s;

   // A new issue is taken only where the control FSM can advance, and never alongside Abort.
   assign accept_s = ((state_q == S_IDLE) || (state_q == S_WB)) && bus.Start && !bus.Abort;
   assign lat_s    = fixed_lat(op_q, ADD_LAT, MUL_LAT);

   // Next-state, latch and counter control.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rd_d       = rd_q;
      err_d      = err_q;
      cnt_load_s = 1'b0;
      cnt_val_s  = {CNTW{1'b0}};
      cnt_dec_s  = 1'b0;
      cnt_clr_s  = 1'b0;
      case (state_q)
         S_IDLE, S_WB: begin
            if (accept_s) begin
               state_d = S_ISSUE;
               op_d    = bus.FpOp;
               rd_d    = bus.Rd;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (bus.Abort) begin
               state_d   = S_IDLE;
               cnt_clr_s = 1'b1;
            end else if (op_q == FP_DIV) begin
               state_d    = S_WAIT;
               cnt_load_s = 1'b1;
               cnt_val_s  = cnt_t'(DIV_TIMEOUT);
            end else if (lat_s == cnt_t'(1)) begin
               state_d = S_WB;
            end else begin
               state_d    = S_WAIT;
               cnt_load_s = 1'b1;
               cnt_val_s  = lat_s - cnt_t'(1);
            end
         end
         S_WAIT: begin
            if (bus.Abort) begin
               state_d   = S_IDLE;
               cnt_clr_s = 1'b1;
            end else if (op_q == FP_DIV) begin
               if (bus.FPUDone) begin
                  state_d   = S_WB;
                  cnt_clr_s = 1'b1;
               end else if (cnt_is_one_s) begin
                  state_d   = S_IDLE;
                  err_d     = 1'b1;
                  cnt_clr_s = 1'b1;
               end else begin
                  cnt_dec_s = 1'b1;
               end
            end else if (cnt_is_one_s) begin
               state_d   = S_WB;
               cnt_clr_s = 1'b1;
            end else begin
               cnt_dec_s = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            cnt_clr_s = 1'b1;
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be registered without extra latency.
   always_comb begin
      fpu_start_d = (state_d == S_ISSUE);
      stall_d     = (state_d == S_ISSUE) || (state_d == S_WAIT);
      fpu_write_d = (state_d == S_WB);
      busy_d      = (state_d != S_IDLE);
   end

   // State, latched op/dest, sticky error and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= FP_ADD;
         rd_q        <= 4'd0;
         err_q       <= 1'b0;
         fpu_start_q <= 1'b0;
         stall_q     <= 1'b0;
         fpu_write_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
         fpu_start_q <= fpu_start_d;
         stall_q     <= stall_d;
         fpu_write_q <= fpu_write_d;
         busy_q      <= busy_d;
      end
   end

   fpu_latcnt #(.W(CNTW)) u_latcnt (
      .clk      (clk),
      .rst      (reset),
      .load     (cnt_load_s),
      .load_val (cnt_val_s),
      .dec      (cnt_dec_s),
      .clr      (cnt_clr_s),
      .is_one   (cnt_is_one_s)
   );

   assign bus.FPUStart = fpu_start_q;
   assign bus.FPUOp    = op_q;
   assign bus.Stall    = stall_q;
   assign bus.FPUWrite = fpu_write_q;
   assign bus.WA3F     = rd_q;
   assign bus.Busy     = busy_q;
   assign bus.FpErr    = err_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed scoreboard bench for fpu_sequencer: expected writes are queued at issue
// and matched by a write monitor; a second instance covers the 1-cycle add latency.
module tb_fpu_sequencer;
   import fpu_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   typedef struct {
      logic [3:0] rd;
      int         cyc;
   } wr_t;
   wr_t sb_q[$];

   fpu_sequencer_if bus ();
   fpu_sequencer_if bus2 ();

   fpu_sequencer u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   fpu_sequencer #(.ADD_LAT(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write monitor: every FPUWrite must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.FPUWrite === 1'b1) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_write observed=WA3F %0d at cycle %0d expected=no write", bus.WA3F, cyc);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            chk("write_rd", 32'(bus.WA3F), 32'(e.rd));
            chk("write_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int t;
      reset = 1'b1;
      bus.Start = 1'b0; bus.FpOp = FP_ADD; bus.Rd = 4'd0; bus.Abort = 1'b0; bus.FPUDone = 1'b0;
      bus2.Start = 1'b0; bus2.FpOp = FP_ADD; bus2.Rd = 4'd0; bus2.Abort = 1'b0; bus2.FPUDone = 1'b0;
      step(); step();
      chk("rst_start", 32'(bus.FPUStart), 32'd0);
      chk("rst_stall", 32'(bus.Stall), 32'd0);
      chk("rst_write", 32'(bus.FPUWrite), 32'd0);
      chk("rst_busy", 32'(bus.Busy), 32'd0);
      chk("rst_err", 32'(bus.FpErr), 32'd0);
      chk("rst_op", 32'(bus.FPUOp), 32'd0);
      chk("rst_wa3f", 32'(bus.WA3F), 32'd0);
      reset = 1'b0;
      step();

      // 1: add Rd=5, write 2 cycles after start
      t = cyc;
      bus.Start = 1'b1; bus.FpOp = FP_ADD; bus.Rd = 4'd5;
      sb_q.push_back('{rd: 4'd5, cyc: t + 3});
      step(); bus.Start = 1'b0;
      chk("add_start", 32'(bus.FPUStart), 32'd1);
      chk("add_stall1", 32'(bus.Stall), 32'd1);
      chk("add_op", 32'(bus.FPUOp), 32'(FP_ADD));
      step();
      chk("add_start_off", 32'(bus.FPUStart), 32'd0);
      chk("add_stall2", 32'(bus.Stall), 32'd1);
      step();
      chk("add_wb_write", 32'(bus.FPUWrite), 32'd1);
      chk("add_wb_stall", 32'(bus.Stall), 32'd0);
      step();
      chk("add_idle_busy", 32'(bus.Busy), 32'd0);
      chk("add_idle_write", 32'(bus.FPUWrite), 32'd0);

      // 2: mul back-to-back, second issued during first write-back
      t = cyc;
      bus.Start = 1'b1; bus.FpOp = FP_MUL; bus.Rd = 4'd2;
      sb_q.push_back('{rd: 4'd2, cyc: t + 4});
      step(); bus.Start = 1'b0;
      step(); step(); step();
      chk("mul1_wb", 32'(bus.FPUWrite), 32'd1);
      bus.Start = 1'b1; bus.FpOp = FP_MUL; bus.Rd = 4'd3;
      sb_q.push_back('{rd: 4'd3, cyc: cyc + 4});
      step(); bus.Start = 1'b0;
      chk("mul2_start", 32'(bus.FPUStart), 32'd1);
      chk("mul2_wa3f", 32'(bus.WA3F), 32'd3);
      step(); step(); step();
      chk("mul2_wb", 32'(bus.FPUWrite), 32'd1);
      step();
      chk("mul2_idle", 32'(bus.Busy), 32'd0);

      // 3a: div completed by FPUDone 10 cycles after FPUStart
      bus.Start = 1'b1; bus.FpOp = FP_DIV; bus.Rd = 4'd7;
      step(); bus.Start = 1'b0;
      t = cyc;
      chk("div_start", 32'(bus.FPUStart), 32'd1);
      sb_q.push_back('{rd: 4'd7, cyc: t + 11});
      repeat (10) step();
      chk("div_wait_stall", 32'(bus.Stall), 32'd1);
      bus.FPUDone = 1'b1;
      step(); bus.FPUDone = 1'b0;
      chk("div_wb", 32'(bus.FPUWrite), 32'd1);
      chk("div_err", 32'(bus.FpErr), 32'd0);
      step();

      // 3b: div without FPUDone times out after 32 WAIT cycles
      bus.Start = 1'b1; bus.FpOp = FP_DIV; bus.Rd = 4'd8;
      step(); bus.Start = 1'b0;
      repeat (32) step();
      chk("to_busy_last", 32'(bus.Busy), 32'd1);
      chk("to_err_pending", 32'(bus.FpErr), 32'd0);
      step();
      chk("to_busy", 32'(bus.Busy), 32'd0);
      chk("to_err", 32'(bus.FpErr), 32'd1);
      chk("to_write", 32'(bus.FPUWrite), 32'd0);
      step();
      chk("to_err_sticky", 32'(bus.FpErr), 32'd1);

      // 4: abort during mul WAIT
      bus.Start = 1'b1; bus.FpOp = FP_MUL; bus.Rd = 4'd6;
      step(); bus.Start = 1'b0;
      step();
      bus.Abort = 1'b1;
      step(); bus.Abort = 1'b0;
      chk("abort_busy", 32'(bus.Busy), 32'd0);
      chk("abort_stall", 32'(bus.Stall), 32'd0);
      step(); step(); step();
      chk("abort_write", 32'(bus.FPUWrite), 32'd0);

      // Abort together with Start in IDLE drops the issue
      bus.Start = 1'b1; bus.Abort = 1'b1; bus.FpOp = FP_ADD; bus.Rd = 4'd1;
      step(); bus.Start = 1'b0; bus.Abort = 1'b0;
      chk("abort_start_busy", 32'(bus.Busy), 32'd0);
      chk("abort_start_pulse", 32'(bus.FPUStart), 32'd0);

      // 5: async reset mid-div, then a normal add
      bus.Start = 1'b1; bus.FpOp = FP_DIV; bus.Rd = 4'd9;
      step(); bus.Start = 1'b0;
      step(); step(); step();
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
      chk("mid_rst_stall", 32'(bus.Stall), 32'd0);
      chk("mid_rst_err", 32'(bus.FpErr), 32'd0);
      chk("mid_rst_op", 32'(bus.FPUOp), 32'd0);
      chk("mid_rst_wa3f", 32'(bus.WA3F), 32'd0);
      step();
      reset = 1'b0;
      step();
      t = cyc;
      bus.Start = 1'b1; bus.FpOp = FP_SUB; bus.Rd = 4'd4;
      sb_q.push_back('{rd: 4'd4, cyc: t + 3});
      step(); bus.Start = 1'b0;
      chk("post_rst_op", 32'(bus.FPUOp), 32'(FP_SUB));
      step(); step();
      chk("post_rst_wb", 32'(bus.FPUWrite), 32'd1);
      step();

      // 6: ADD_LAT=1 instance goes ISSUE -> WB without WAIT
      bus2.Start = 1'b1; bus2.FpOp = FP_ADD; bus2.Rd = 4'hA;
      step(); bus2.Start = 1'b0;
      chk("lat1_start", 32'(bus2.FPUStart), 32'd1);
      chk("lat1_no_write", 32'(bus2.FPUWrite), 32'd0);
      step();
      chk("lat1_write", 32'(bus2.FPUWrite), 32'd1);
      chk("lat1_wa3f", 32'(bus2.WA3F), 32'hA);
      chk("lat1_stall", 32'(bus2.Stall), 32'd0);
      step();
      chk("lat1_idle", 32'(bus2.Busy), 32'd0);

      repeat (4) step();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
